// File: rtl/column_linebuffer_pkg.sv
// Shared constants and width helpers for the column line buffer and its
// downstream kernel shift register.
package column_linebuffer_pkg;

  localparam int PIXEL_W = 8;

  // Counter width for a column index; at least 1 bit so a 1-wide image still elaborates.
  function automatic int col_w(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int row_w(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

endpackage

// File: rtl/column_linebuffer_line_ram.sv
// One image line of storage: synchronous write, asynchronous read on a
// shared address so a read-modify-write completes in a single cycle.
module line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; clearing it would force flops instead
  // of RAM, and stale lines are never observed because fill rows are suppressed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/column_linebuffer.sv
// Raster pixel stream in, one vertical BLOCK_HEIGHT column out per pixel once
// enough lines have been buffered; 1-deep output register with pass-through.
module column_linebuffer
  import column_linebuffer_pkg::*;
#(
  parameter int DATA_WIDTH   = PIXEL_W,
  parameter int BLOCK_HEIGHT = 3,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DATA_WIDTH*BLOCK_HEIGHT-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int COL_W = col_w(IMG_WIDTH);
  localparam int ROW_W = row_w(IMG_HEIGHT);
  localparam int LINES = BLOCK_HEIGHT - 1;
  localparam int OUT_W = DATA_WIDTH * BLOCK_HEIGHT;

  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic             acc;
  logic             col_wrap;
  logic             row_wrap;
  logic             fill_done;
  logic [OUT_W-1:0] col_data;

  logic [DATA_WIDTH-1:0] rd_data [LINES];
  logic [DATA_WIDTH-1:0] wr_data [LINES];

  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // Each line shifts one step older on every accept; the newest takes the pixel.
  for (genvar g = 0; g < LINES; g++) begin : g_line
    if (g == LINES - 1) begin : g_newest
      assign wr_data[g] = in_data;
    end else begin : g_older
      assign wr_data[g] = rd_data[g+1];
    end

    line_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH),
      .ADDR_W    (COL_W)
    ) u_line_ram (
      .clk    (clk),
      .we_i   (acc),
      .addr_i (col_cnt_q),
      .wdata_i(wr_data[g]),
      .rdata_o(rd_data[g])
    );
  end

  // Slice 0 is the live pixel; the oldest line lands in the top slice.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    col_data                = '0;
    col_data[DATA_WIDTH-1:0] = in_data;
    for (int j = 0; j < LINES; j++) begin
      col_data[(BLOCK_HEIGHT-1-j)*DATA_WIDTH +: DATA_WIDTH] = rd_data[j];
    end
  end

  assign col_wrap  = (col_cnt_q == COL_W'(IMG_WIDTH - 1));
  assign row_wrap  = (row_cnt_q == ROW_W'(IMG_HEIGHT - 1));
  assign fill_done = (row_cnt_q >= ROW_W'(BLOCK_HEIGHT - 1));

  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (acc) begin
      col_cnt_d   = col_wrap ? '0 : col_cnt_q + 1'b1;
      out_valid_d = fill_done;
      out_data_d  = col_data;
      if (col_wrap) begin
        row_cnt_d = row_wrap ? '0 : row_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_column_linebuffer.sv
// Scoreboard bench: the monitor models accepted pixels as a 2-D frame and
// compares every handshaked column against the expected queue.
module tb_column_linebuffer;

  localparam int DW = 8;
  localparam int BH = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int OW = DW * BH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  column_linebuffer #(
    .DATA_WIDTH  (DW),
    .BLOCK_HEIGHT(BH),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model state: the current frame as a plain 2-D image.
  logic [DW-1:0] img [H][W];
  int            m_row = 0;
  int            m_col = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] popped_q[$];
  int            out_cnt = 0;
  int            acc_cnt = 0;
  int            push_cnt = 0;
  int            first_valid_acc = -1;
  int            ready_mode = 0;   // 0: always ready, 1: random
  bit            hold_arm = 1'b0;
  bit            hold_active = 1'b0;
  int            hold_cycles = 0;

  task automatic model_accept(input logic [DW-1:0] d);
    logic [OW-1:0] c;
    img[m_row][m_col] = d;
    if (m_row >= BH - 1) begin
      c = '0;
      c[DW-1:0] = d;
      for (int k = 1; k < BH; k++) c[k*DW +: DW] = img[m_row-k][m_col];
      exp_q.push_back(c);
      push_cnt++;
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end
  endtask

  // Monitor: mid-cycle sampling sees exactly what the next posedge will act on.
  always @(negedge clk) begin
    logic [OW-1:0] e;
    if (rst) begin
      exp_q.delete();
      m_row = 0;
      m_col = 0;
    end else begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (hold_active) begin
        hold_cycles++;
        check("hold_data", out_data, 24'h011121);
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (out_valid && first_valid_acc < 0) first_valid_acc = acc_cnt;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_column");
        end else begin
          e = exp_q.pop_front();
          check("column", out_data, e);
        end
        popped_q.push_back(out_data);
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        model_accept(in_data);
        acc_cnt++;
      end
    end
  end

  // Downstream ready driver, with a one-shot hold on column 0x011121.
  always begin
    @(posedge clk);
    #1;
    if (hold_arm && out_valid && out_data == 24'h011121) begin
      hold_arm    = 1'b0;
      hold_active = 1'b1;
      out_ready   = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      hold_active = 1'b0;
      out_ready   = 1'b1;
    end else begin
      out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [DW-1:0] d);
    bit took = 1'b0;
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!took && n < 100) begin
      @(negedge clk);
      took = in_ready && !rst;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!took) fail_now("send_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: back-to-back, 1: one idle cycle after each pixel, 2: random gaps and data
  task automatic stream_frame(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (mode == 2) begin
          idle($urandom_range(0, 2));
          send(DW'($urandom));
        end else begin
          send(DW'(r * 16 + c));
          if (mode == 1) idle(1);
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(3);
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic begin_test();
    out_cnt = 0;
    acc_cnt = 0;
    push_cnt = 0;
    first_valid_acc = -1;
    popped_q.delete();
  endtask

  function automatic logic [OW-1:0] pq(input int i);
    return (i >= 0 && i < popped_q.size()) ? popped_q[i] : 24'hffffff;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    void'($urandom(32'h5eed_c01));
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 24'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: full-rate frame
    begin_test();
    stream_frame(0);
    drain();
    check("t1_first_valid_after_acc", first_valid_acc, 9);
    check("t1_count", out_cnt, 8);
    check("t1_first", pq(0), 24'h001020);
    check("t1_last", pq(7), 24'h132333);

    // 2: back-pressure hold on the second column
    begin_test();
    hold_cycles = 0;
    hold_arm = 1'b1;
    stream_frame(0);
    drain();
    check("t2_hold_cycles", hold_cycles, 5);
    check("t2_count", out_cnt, 8);
    check("t2_held", pq(1), 24'h011121);
    check("t2_after_release", pq(2), 24'h021222);

    // 3: in_valid toggling
    begin_test();
    stream_frame(1);
    drain();
    check("t3_count", out_cnt, 8);
    check("t3_first", pq(0), 24'h001020);
    check("t3_last", pq(7), 24'h132333);

    // 4: two back-to-back frames
    begin_test();
    stream_frame(0);
    stream_frame(0);
    drain();
    check("t4_count", out_cnt, 16);
    check("t4_frame2_first", pq(8), 24'h001020);
    check("t4_frame2_last", pq(15), 24'h132333);

    // 5: reset mid-frame after pixel 0x12
    begin_test();
    for (int p = 0; p < 7; p++) send(DW'((p / W) * 16 + (p % W)));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_reset", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    begin_test();
    stream_frame(0);
    drain();
    check("t5_first_valid_after_acc", first_valid_acc, 9);
    check("t5_count", out_cnt, 8);
    check("t5_first", pq(0), 24'h001020);

    // 6: random valid/ready and random data over three frames
    begin_test();
    ready_mode = 1;
    for (int f = 0; f < 3; f++) stream_frame(2);
    drain();
    check("t6_count", out_cnt, push_cnt);
    check("t6_expected_total", push_cnt, 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/column_linebuffer.md
Name: column_linebuffer

Overview:
Upstream neighbour of the horizontal kernel shift register in the HOG pipeline.
- Accepts a raster-order pixel stream, one pixel per handshake.
- Stores BLOCK_HEIGHT-1 previous image lines.
- For each accepted pixel, emits one vertical column of BLOCK_HEIGHT pixels: the current pixel plus the pixels at the same column in the previous lines.
- The downstream kernel shift register turns successive columns into a 2-D window.

Parameters:
DATA_WIDTH, 8, bits per pixel
BLOCK_HEIGHT, 3, column height in pixels (must be >= 2)
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
in_data  in  DATA_WIDTH  pixel from upstream
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a pixel this cycle
out_data  out  DATA_WIDTH*BLOCK_HEIGHT  column; slice k (bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]) = pixel from line row-k, so slice 0 is the current line
out_valid  out  1  out_data holds a valid column
out_ready  in  1  downstream accepts the column

Behaviour:
- Reset (rst=1 at posedge):
  - col_cnt=0, row_cnt=0, out_valid=0, out_data=0.
  - Line memories are not cleared.
  - in_ready is combinational and reads 1 once out_valid=0.
- Accept: acc = in_valid & in_ready.
- in_ready = !out_valid | out_ready. This is a 1-deep output register with pass-through on a simultaneous pop and push.
- Line storage:
  - lines L[0..BLOCK_HEIGHT-2], each IMG_WIDTH deep, addressed by col_cnt, asynchronous read.
  - L[0] is the oldest line; L[BLOCK_HEIGHT-2] is the previous line.
- On acc at column c, in the same edge:
  - Column register captures {L[0][c], ..., L[BLOCK_HEIGHT-2][c], in_data}, with in_data in slice 0 and L[j][c] in slice BLOCK_HEIGHT-1-j.
  - Reads happen before writes.
  - Memory cascade: L[j][c] <= L[j+1][c] for j < BLOCK_HEIGHT-2, and L[BLOCK_HEIGHT-2][c] <= in_data.
- out_valid after an acc edge:
  - 1 if the pre-increment row_cnt >= BLOCK_HEIGHT-1.
  - 0 otherwise (fill rows are consumed silently). In that case, if the previous column is popped at the same edge, out_valid drops to 0.
- No acc and out_ready=1 with out_valid=1: out_valid <= 0 at the edge.
- Hold: while out_valid=1 and out_ready=0, out_data and out_valid are stable and in_ready=0.
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 column/cycle with in_valid=out_ready=1.
- Counters:
  - col_cnt increments on acc and wraps IMG_WIDTH-1 -> 0.
  - On wrap, row_cnt increments and wraps IMG_HEIGHT-1 -> 0 (end of frame).
  - At frame wrap, stale memory contents remain but are masked by fill-row suppression.
- Columns per frame: (IMG_HEIGHT-BLOCK_HEIGHT+1)*IMG_WIDTH.
- Reset mid-frame: counters return to 0, any pending column is discarded, and the next accepted pixel is treated as (row 0, col 0).
- Widths: col_cnt is clog2(IMG_WIDTH) bits and row_cnt is clog2(IMG_HEIGHT) bits. Wrap uses explicit compare, not natural overflow.

Decomposition:
- Shared package holds:
  - COL_W = clog2(IMG_WIDTH) and ROW_W = clog2(IMG_HEIGHT) helper functions.
  - Pixel width constant, common with the kernel shift register.
- One sub-module, line_ram: single-line memory, IMG_WIDTH x DATA_WIDTH, synchronous write, asynchronous read, instantiated BLOCK_HEIGHT-1 times in a generate loop.
- Top level holds the counters, handshake and column register.

Test Plan:
Bench parameters: DATA_WIDTH=8, BLOCK_HEIGHT=3, IMG_WIDTH=4, IMG_HEIGHT=4. Pixel value = row*16+col.
1. Stream 16 pixels with in_valid=out_ready=1.
   - No out_valid for the first 8 accepts.
   - After pixel 0x20 is accepted: out_valid=1, out_data=0x001020.
   - Last column is 0x132333.
   - Exactly 8 columns total.
2. Hold out_ready=0 when column 0x011121 is presented.
   - in_ready=0 and out_data stays 0x011121 for 5 cycles.
   - On release, the next column is 0x021222 with no loss or duplication.
3. Toggle in_valid 1/0 every cycle over the full frame.
   - Same 8 columns, same order.
   - out_valid is never high for two cycles on a single column with out_ready=1.
4. Stream two back-to-back frames.
   - Frame 2 pixels 0..7 produce no output.
   - Frame 2 first column after (2,0) is 0x001020 again.
   - 16 columns total.
5. Assert rst for 1 cycle after pixel 0x12 is accepted, then restart the frame.
   - out_valid=0 on the cycle after reset.
   - Output resumes only after the new row 2 col 0, with value 0x001020.
6. Sweep random in_valid and out_ready (seeded).
   - Scoreboard from a reference column model matches every handshaked output.
   - in_ready always equals !out_valid | out_ready.
